tcdm_bank_rr_arbiter: RTL
=========================

Name: tcdm_bank_rr_arbiter

Overview:
- Per-bank request arbiter; sits directly upstream of one TCDM bank wrapper port.
- Merges NbMasters OBI-style memory requesters (cores, DMA, HWPE ports) onto the single bank slave port using round-robin.
- Routes the bank's 1-cycle-latency read data back to the master that issued the request.
- Holds a stalled grant while the bank withholds gnt, e.g. during an ECC bank's scrub or read-modify-write.

Parameters:
- NbMasters, 4, number of requesting ports; >=2.
- DataWidth, 32, data width.
- AddrWidth, 32, address width.
- BeWidth, DataWidth/8, byte-enable width.
- IdWidth, 1, transaction id width, passed through unchanged.
- IdxWidth, $clog2(NbMasters), master index width (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset: asynchronous, active-low.
- mst_req_i  in  [NbMasters]  request per master.
- mst_gnt_o  out  [NbMasters]  grant per master.
- mst_wen_i  in  [NbMasters]  1 = read, 0 = write.
- mst_add_i  in  [NbMasters][AddrWidth]  byte address.
- mst_data_i  in  [NbMasters][DataWidth]  write data.
- mst_be_i  in  [NbMasters][BeWidth]  byte enables.
- mst_id_i  in  [NbMasters][IdWidth]  request id.
- mst_r_valid_o  out  [NbMasters]  response valid, one cycle.
- mst_r_data_o  out  [NbMasters][DataWidth]  read data; broadcast to all masters, qualified by r_valid.
- mst_r_id_o  out  [NbMasters][IdWidth]  response id; broadcast.
- bank_req_o  out  1  request to bank.
- bank_gnt_i  in  1  bank grant.
- bank_wen_o  out  1  to bank.
- bank_add_o  out  AddrWidth  to bank.
- bank_data_o  out  DataWidth  to bank.
- bank_be_o  out  BeWidth  to bank.
- bank_id_o  out  IdWidth  to bank.
- bank_r_data_i  in  DataWidth  bank read data, valid 1 cycle after handshake.
- bank_r_id_i  in  IdWidth  bank response id, registered by the bank.

Behaviour:

State:
- rr_ptr_q (IdxWidth): highest-priority master.
- lock_q / lock_idx_q: stall hold.
- rsp_valid_q / rsp_idx_q: response routing.
- All reset to 0.

Arbitration:
- Combinational.
- If lock_q=1, winner = lock_idx_q.
- Else winner = first requesting master at or after rr_ptr_q, scanning upward with wrap NbMasters-1 -> 0.
- No requester: bank_req_o=0.

Request path:
- bank_req_o = |mst_req_i (or lock_q).
- bank_* payload = winner's fields, muxed combinationally with zero added latency.
- mst_gnt_o[winner] = bank_gnt_i & bank_req_o; all other grants 0.
- At most one mst_gnt_o bit is ever high.

Handshake (bank_req_o & bank_gnt_i):
- rr_ptr_q <= winner+1, wrapping at NbMasters.
- lock_q <= 0.
- rsp_valid_q <= 1; rsp_idx_q <= winner.

Stall (bank_req_o & ~bank_gnt_i):
- lock_q <= 1; lock_idx_q <= winner; rr_ptr_q unchanged.
- Masters keep req and payload stable until gnt. If a locked master drops req anyway (protocol violation), lock_q clears the next cycle and arbitration resumes; a simulation assertion flags it.

Otherwise:
- rsp_valid_q <= 0.

Response path:
- mst_r_valid_o[i] = rsp_valid_q & (rsp_idx_q == i).
- Issued for both reads and writes; a write response carries don't-care data.
- Back-to-back handshakes produce back-to-back responses to possibly different masters.
- No backpressure on responses.

Reset:
- All outputs 0 during reset, including bank_req_o.
- Reset mid-stall drops the lock and any pending r_valid.

Simultaneous events:
- Handshake and new requests in the same cycle: the new winner is computed from the updated pointer the next cycle.
- All masters requesting continuously: each master is served exactly once every NbMasters handshakes.

Decomposition:
- tcdm_arb_pkg: idx_t (IdxWidth) and an rr-next function (wrap increment).
- One sub-module, tcdm_rr_pick: combinational priority scan from a pointer; returns winner index and valid.

Test Plan:
- Single master: master 2 reads addr 0x40, gnt=1 -> bank_add_o=0x40 same cycle; mst_r_valid_o=4'b0100 next cycle with bank_r_data_i, id echoed.
- All 4 requesting continuously, gnt=1 -> grant order 0,1,2,3,0,1 on consecutive cycles; r_valid follows one cycle later in the same order.
- Stall: masters 1 and 3 request, gnt=0 for 3 cycles -> grant held on master 1, payload stable, no switch to 3; gnt=1 -> master 1 served, master 3 next cycle.
- Pointer wrap: rr_ptr=3, requests from 0 and 3 -> 3 first, then 0; rr_ptr ends at 1.
- Reset asserted during a stall with pending r_valid -> all outputs 0 asynchronously; after release, first request is served from index 0.
- Write then read to the same master back-to-back -> two consecutive r_valid pulses; read data matches the earlier written data with be=4'b1111.

Source files
------------

// File: rtl/tcdm_arb_pkg.sv
// rtl/tcdm_arb_pkg.sv - shared types and helpers for the TCDM bank round-robin arbiter
package tcdm_arb_pkg;

    localparam int unsigned NbMastersDefault = 4;
    localparam int unsigned IdxWidthDefault  = $clog2(NbMastersDefault);

    typedef logic [IdxWidthDefault-1:0] idx_t;

    // Round-robin successor: idx + 1, wrapping back to 0 after n - 1.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tcdm_bank_rr_arbiter_if.sv
// rtl/tcdm_bank_rr_arbiter_if.sv - master-side and bank-side OBI signals of one bank arbiter
interface tcdm_bank_rr_arbiter_if
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NbMasters = NbMastersDefault,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned IdWidth   = 1
);

    logic [NbMasters-1:0]                mst_req_i;
    logic [NbMasters-1:0]                mst_gnt_o;
    logic [NbMasters-1:0]                mst_wen_i;
    logic [NbMasters-1:0][AddrWidth-1:0] mst_add_i;
    logic [NbMasters-1:0][DataWidth-1:0] mst_data_i;
    logic [NbMasters-1:0][BeWidth-1:0]   mst_be_i;
    logic [NbMasters-1:0][IdWidth-1:0]   mst_id_i;
    logic [NbMasters-1:0]                mst_r_valid_o;
    logic [NbMasters-1:0][DataWidth-1:0] mst_r_data_o;
    logic [NbMasters-1:0][IdWidth-1:0]   mst_r_id_o;

    logic                 bank_req_o;
    logic                 bank_gnt_i;
    logic                 bank_wen_o;
    logic [AddrWidth-1:0] bank_add_o;
    logic [DataWidth-1:0] bank_data_o;
    logic [BeWidth-1:0]   bank_be_o;
    logic [IdWidth-1:0]   bank_id_o;
    logic [DataWidth-1:0] bank_r_data_i;
    logic [IdWidth-1:0]   bank_r_id_i;

    // Arbiter side.
    modport slave (
        input  mst_req_i, mst_wen_i, mst_add_i, mst_data_i, mst_be_i, mst_id_i,
        input  bank_gnt_i, bank_r_data_i, bank_r_id_i,
        output mst_gnt_o, mst_r_valid_o, mst_r_data_o, mst_r_id_o,
        output bank_req_o, bank_wen_o, bank_add_o, bank_data_o, bank_be_o, bank_id_o
    );

    // Environment side: the requesting masters together with the bank.
    modport master (
        output mst_req_i, mst_wen_i, mst_add_i, mst_data_i, mst_be_i, mst_id_i,
        output bank_gnt_i, bank_r_data_i, bank_r_id_i,
        input  mst_gnt_o, mst_r_valid_o, mst_r_data_o, mst_r_id_o,
        input  bank_req_o, bank_wen_o, bank_add_o, bank_data_o, bank_be_o, bank_id_o
    );

endinterface

// File: rtl/tcdm_rr_pick.sv
// rtl/tcdm_rr_pick.sv - combinational priority scan starting at a round-robin pointer
module tcdm_rr_pick #(
    parameter int unsigned NbMasters = 4,
    parameter int unsigned IdxWidth  = $clog2(NbMasters)
) (
    input  logic [NbMasters-1:0] req,
    input  logic [IdxWidth-1:0]  ptr,
    output logic [IdxWidth-1:0]  idx,
    output logic                 valid
);

    always_comb begin
        logic [IdxWidth-1:0] cand;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        // Candidates are visited ptr, ptr+1, ... wrapping; the first requester wins.
        for (int unsigned k = 0; k < NbMasters; k++) begin
            cand = IdxWidth'((32'(ptr) + k) % NbMasters);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tcdm_bank_rr_arbiter.sv
// rtl/tcdm_bank_rr_arbiter.sv - round-robin merge of NbMasters OBI requesters onto one TCDM bank port
module tcdm_bank_rr_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NbMasters = NbMastersDefault,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned IdxWidth  = $clog2(NbMasters)
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    tcdm_bank_rr_arbiter_if.slave bus
);

    logic [IdxWidth-1:0]  rr_ptr_q;
    logic                 lock_q;
    logic [IdxWidth-1:0]  lock_idx_q;
    logic                 rsp_valid_q;
    logic [IdxWidth-1:0]  rsp_idx_q;

    logic [IdxWidth-1:0]  pick_idx;
    logic                 pick_valid;
    logic                 lock_hold;
    logic [IdxWidth-1:0]  winner;
    logic                 req_any;
    logic                 handshake;
    logic                 stall;

    logic                 wen_mux;
    logic [AddrWidth-1:0] add_mux;
    logic [DataWidth-1:0] data_mux;
    logic [BeWidth-1:0]   be_mux;
    logic [IdWidth-1:0]   id_mux;

    tcdm_rr_pick #(
        .NbMasters (NbMasters),
        .IdxWidth  (IdxWidth)
    ) i_pick (
        .req   (bus.mst_req_i),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // A stalled grant sticks to its master; if that master abandons the request
    // the lock is ignored at once and dropped from state on the next edge.
    assign lock_hold = lock_q & bus.mst_req_i[lock_idx_q];
    assign winner    = lock_hold ? lock_idx_q : pick_idx;

    assign req_any   = rst_ni & pick_valid;
    assign handshake = req_any & bus.bank_gnt_i;
    assign stall     = req_any & ~bus.bank_gnt_i;

    assign wen_mux  = bus.mst_wen_i[winner];
    assign add_mux  = bus.mst_add_i[winner];
    assign data_mux = bus.mst_data_i[winner];
    assign be_mux   = bus.mst_be_i[winner];
    assign id_mux   = bus.mst_id_i[winner];

    // Every output is forced low while reset is asserted, payload included.
    assign bus.bank_req_o  = req_any;
    assign bus.bank_wen_o  = rst_ni ? wen_mux  : 1'b0;
    assign bus.bank_add_o  = rst_ni ? add_mux  : '0;
    assign bus.bank_data_o = rst_ni ? data_mux : '0;
    assign bus.bank_be_o   = rst_ni ? be_mux   : '0;
    assign bus.bank_id_o   = rst_ni ? id_mux   : '0;

    always_comb begin
        bus.mst_gnt_o     = '0;
        bus.mst_r_valid_o = '0;
        bus.mst_r_data_o  = '0;
        bus.mst_r_id_o    = '0;
        for (int unsigned i = 0; i < NbMasters; i++) begin
            bus.mst_gnt_o[i]     = handshake & (winner == IdxWidth'(i));
            bus.mst_r_valid_o[i] = rsp_valid_q & (rsp_idx_q == IdxWidth'(i));
            bus.mst_r_data_o[i]  = rst_ni ? bus.bank_r_data_i : '0;
            bus.mst_r_id_o[i]    = rst_ni ? bus.bank_r_id_i   : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
        end else if (handshake) begin
            rr_ptr_q    <= IdxWidth'(rr_next(32'(winner), NbMasters));
            lock_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_idx_q   <= winner;
        end else if (stall) begin
            lock_q      <= 1'b1;
            lock_idx_q  <= winner;
            rsp_valid_q <= 1'b0;
        end else begin
            lock_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end
    end

    a_locked_req_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni) lock_q |-> bus.mst_req_i[lock_idx_q]
    ) else $error("tcdm_bank_rr_arbiter: locked master dropped its request before grant");

endmodule
